// File: rtl/toggle_mon_pkg.sv
// Shared types and width helpers for the toggle activity monitor.
// The optional peak output is enabled with the TOGGLE_MON_PEAK_EN macro in the top.
package toggle_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        COUNT = 2'd2
    } state_t;

    // Wide enough for a window in which every net toggles on every cycle.
    function automatic int cnt_width(input int width, input int window);
        return $clog2(width * window + 1);
    endfunction

    function automatic int pc_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/toggle_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module toggle_popcount
    import toggle_mon_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int PC_W  = pc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [PC_W-1:0]  count
);

    // Written as a linear sum; synthesis rebalances it into an adder tree.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count = count + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/toggle_activity_monitor.sv
// Counts net toggles over fixed windows and streams per-window totals on valid/ready.
// Define TOGGLE_MON_PEAK_EN to add OUT_PEAK, the largest single-cycle toggle count in the window.
module toggle_activity_monitor
    import toggle_mon_pkg::*;
#(
    parameter int WIDTH  = 24,
    parameter int WINDOW = 256,
    parameter int CNT_W  = cnt_width(WIDTH, WINDOW),
    parameter int SEQ_W  = 8
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic             CLR_OVR,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] OUT_DATA,
    output logic [SEQ_W-1:0] OUT_SEQ,
    output logic             OVERRUN
`ifdef TOGGLE_MON_PEAK_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] OUT_PEAK
`endif
);

    localparam int PC_W  = pc_width(WIDTH);
    localparam int WIN_W = $clog2(WINDOW);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_prev;
    logic [WIDTH-1:0] toggles;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] final_sum;
    logic [WIN_W-1:0] win;
    logic [SEQ_W-1:0] seq;
    logic             counting;
    logic             complete;
    logic             load;
    logic             drop;

    assign toggles = A ^ a_prev;

    toggle_popcount #(
        .WIDTH (WIDTH),
        .PC_W  (PC_W)
    ) u_popcount (
        .bits  (toggles),
        .count (pc)
    );

    assign final_sum = acc + CNT_W'(pc);
    assign counting  = (state_q == COUNT) && EN;
    assign complete  = counting && (win == WIN_LAST);
    // A finished window may replace the held sample only if that slot is free or draining now.
    assign load      = complete && (!OUT_VALID || OUT_READY);
    assign drop      = complete && !load;

`ifdef TOGGLE_MON_PEAK_EN
    logic [PC_W-1:0] peak;
    logic [PC_W-1:0] peak_final;
    assign peak_final = (pc > peak) ? pc : peak;
`endif

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = EN ? PRIME : IDLE;
            PRIME:   state_d = EN ? COUNT : IDLE;
            COUNT:   state_d = EN ? COUNT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Window accumulation stage
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            a_prev <= '0;
            acc    <= '0;
            win    <= '0;
            seq    <= '0;
`ifdef TOGGLE_MON_PEAK_EN
            peak   <= '0;
`endif
        end else begin
            case (state_q)
                PRIME: begin
                    a_prev <= A;
                    acc    <= '0;
                    win    <= '0;
`ifdef TOGGLE_MON_PEAK_EN
                    peak   <= '0;
`endif
                end
                COUNT: begin
                    if (!EN) begin
                        acc  <= '0;
                        win  <= '0;
`ifdef TOGGLE_MON_PEAK_EN
                        peak <= '0;
`endif
                    end else if (complete) begin
                        a_prev <= A;
                        acc    <= '0;
                        win    <= '0;
                        seq    <= seq + 1'b1;
`ifdef TOGGLE_MON_PEAK_EN
                        peak   <= '0;
`endif
                    end else begin
                        a_prev <= A;
                        acc    <= final_sum;
                        win    <= win + 1'b1;
`ifdef TOGGLE_MON_PEAK_EN
                        peak   <= peak_final;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Output sample stage
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_SEQ   <= '0;
`ifdef TOGGLE_MON_PEAK_EN
            OUT_PEAK  <= '0;
`endif
        end else if (load) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= final_sum;
            OUT_SEQ   <= seq;
`ifdef TOGGLE_MON_PEAK_EN
            OUT_PEAK  <= peak_final;
`endif
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            OVERRUN <= 1'b0;
        end else if (drop) begin
            OVERRUN <= 1'b1;
        end else if (CLR_OVR) begin
            OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Directed and random stimulus for toggle_activity_monitor against a window-list reference model.
// Peak checks are compiled in when TOGGLE_MON_PEAK_EN is defined.
module tb_toggle_activity_monitor;

    localparam int W   = 4;
    localparam int WIN = 4;

    logic       CK = 1'b0;
    logic       RN;
    logic       EN;
    logic [3:0] A;
    logic       CLR_OVR;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [4:0] OUT_DATA;
    logic [7:0] OUT_SEQ;
    logic       OVERRUN;
`ifdef TOGGLE_MON_PEAK_EN
    logic [2:0] OUT_PEAK;
`endif

    toggle_activity_monitor #(
        .WIDTH  (W),
        .WINDOW (WIN),
        .SEQ_W  (8)
    ) dut (
        .CK        (CK),
        .RN        (RN),
        .EN        (EN),
        .A         (A),
        .CLR_OVR   (CLR_OVR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_DATA  (OUT_DATA),
        .OUT_SEQ   (OUT_SEQ),
        .OVERRUN   (OVERRUN)
`ifdef TOGGLE_MON_PEAK_EN
        ,
        .OUT_PEAK  (OUT_PEAK)
`endif
    );

    initial forever #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0 idle, 1 waiting to take first sample, 2 collecting samples.
    int         mode;
    logic [3:0] q[$];
    bit         exp_valid;
    int         exp_data;
    int         exp_seq;
    bit         exp_ovr;
    int         exp_peak;
    int         seqc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        mode      = 0;
        q.delete();
        exp_valid = 0;
        exp_data  = 0;
        exp_seq   = 0;
        exp_ovr   = 0;
        exp_peak  = 0;
        seqc      = 0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_valid"}, 32'(OUT_VALID), 32'(exp_valid));
        check({tag, "_data"}, 32'(OUT_DATA), 32'(exp_data));
        check({tag, "_seq"}, 32'(OUT_SEQ), 32'(exp_seq));
        check({tag, "_ovr"}, 32'(OVERRUN), 32'(exp_ovr));
`ifdef TOGGLE_MON_PEAK_EN
        check({tag, "_peak"}, 32'(OUT_PEAK), 32'(exp_peak));
`endif
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_data"}, 32'(OUT_DATA), 32'd0);
        check({tag, "_seq"}, 32'(OUT_SEQ), 32'd0);
        check({tag, "_ovr"}, 32'(OVERRUN), 32'd0);
`ifdef TOGGLE_MON_PEAK_EN
        check({tag, "_peak"}, 32'(OUT_PEAK), 32'd0);
`endif
    endtask

    // One clock: drive inputs, advance the model, then compare just after the edge.
    task automatic step(input bit en, input logic [3:0] a, input bit rdy, input bit clr, input string tag);
        bit done = 0;
        int fin  = 0;
        int pk   = 0;
        bit drop = 0;
        EN = en; A = a; OUT_READY = rdy; CLR_OVR = clr;
        case (mode)
            0: if (en) mode = 1;
            1: begin
                if (en) begin
                    q = {a};
                    mode = 2;
                end else begin
                    mode = 0;
                end
            end
            default: begin
                if (!en) begin
                    mode = 0;
                    q.delete();
                end else begin
                    q.push_back(a);
                    if (q.size() == WIN + 1) begin
                        for (int i = 0; i < WIN; i++) begin
                            int p;
                            p = $countones(q[i] ^ q[i+1]);
                            fin += p;
                            if (p > pk) pk = p;
                        end
                        done = 1;
                        q = {a};
                    end
                end
            end
        endcase
        if (done) begin
            if (!exp_valid || rdy) begin
                exp_valid = 1;
                exp_data  = fin;
                exp_seq   = seqc;
                exp_peak  = pk;
            end else begin
                drop = 1;
            end
            seqc = (seqc + 1) % 256;
        end else if (exp_valid && rdy) begin
            exp_valid = 0;
        end
        if (drop) exp_ovr = 1;
        else if (clr) exp_ovr = 0;
        @(posedge CK);
        #1;
        check_model(tag);
    endtask

    // Entered at edge+1; asserts reset between edges and checks it takes effect without a clock.
    task automatic do_reset(input string tag);
        #2;
        RN = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(posedge CK);
        #1;
        RN = 1'b1;
    endtask

    initial begin
        RN = 1'b0; EN = 1'b0; A = 4'h0; CLR_OVR = 1'b0; OUT_READY = 1'b0;
        model_reset();
        repeat (2) @(posedge CK);
        #1;
        check_zero("reset");
        RN = 1'b1;

        // Alternating all-zero / all-one nets: every window totals 16.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, (i % 2 == 1) ? 4'hF : 4'h0, 1'b1, 1'b0, "alt");
            if (i == 5 || i == 9 || i == 13) begin
                check("alt_sum", 32'(OUT_DATA), 32'd16);
                check("alt_seqno", 32'(OUT_SEQ), 32'((i - 5) / 4));
            end
        end

        // Constant nets give zero, then a thermometer fill gives four toggles.
        step(1'b0, 4'h5, 1'b1, 1'b0, "const");
        step(1'b1, 4'h5, 1'b1, 1'b0, "const");
        for (int i = 0; i < 5; i++) step(1'b1, 4'h5, 1'b1, 1'b0, "const");
        check("const_sum", 32'(OUT_DATA), 32'd0);
        check("const_vld", 32'(OUT_VALID), 32'd1);
        step(1'b0, 4'h0, 1'b1, 1'b0, "therm");
        step(1'b1, 4'h0, 1'b1, 1'b0, "therm");
        step(1'b1, 4'h0, 1'b1, 1'b0, "therm");
        step(1'b1, 4'h1, 1'b1, 1'b0, "therm");
        step(1'b1, 4'h3, 1'b1, 1'b0, "therm");
        step(1'b1, 4'h7, 1'b1, 1'b0, "therm");
        step(1'b1, 4'hF, 1'b1, 1'b0, "therm");
        check("therm_sum", 32'(OUT_DATA), 32'd4);

        // Backpressure: first sample held, second dropped, overrun flagged and cleared.
        do_reset("rst_bp");
        step(1'b1, 4'h0, 1'b0, 1'b0, "bp");
        step(1'b1, 4'($urandom), 1'b0, 1'b0, "bp");
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 4'($urandom), 1'b0, 1'b0, "bp");
            if (i == 4) check("bp_first_seq", 32'(OUT_SEQ), 32'd0);
        end
        check("bp_ovr_set", 32'(OVERRUN), 32'd1);
        check("bp_held_seq", 32'(OUT_SEQ), 32'd0);
        for (int i = 9; i <= 12; i++) step(1'b1, 4'($urandom), 1'b1, 1'b0, "bp_rel");
        check("bp_next_seq", 32'(OUT_SEQ), 32'd2);
        check("bp_next_vld", 32'(OUT_VALID), 32'd1);
        step(1'b1, 4'($urandom), 1'b0, 1'b1, "bp_clr");
        check("bp_ovr_clr", 32'(OVERRUN), 32'd0);
        step(1'b1, 4'($urandom), 1'b0, 1'b0, "bp_hold");
        step(1'b1, 4'($urandom), 1'b0, 1'b0, "bp_hold");
        step(1'b1, 4'($urandom), 1'b0, 1'b1, "bp_setwins");
        check("bp_set_wins", 32'(OVERRUN), 32'd1);
        step(1'b1, 4'($urandom), 1'b1, 1'b1, "bp_clr2");
        check("bp_ovr_clr2", 32'(OVERRUN), 32'd0);

        // Enable dropped mid-window: partial window discarded, sequence unchanged.
        step(1'b0, 4'h0, 1'b1, 1'b0, "endrop");
        step(1'b1, 4'h0, 1'b1, 1'b0, "endrop");
        step(1'b1, 4'($urandom), 1'b1, 1'b0, "endrop");
        step(1'b1, 4'($urandom), 1'b1, 1'b0, "endrop");
        step(1'b1, 4'($urandom), 1'b1, 1'b0, "endrop");
        step(1'b0, 4'($urandom), 1'b1, 1'b0, "endrop");
        step(1'b0, 4'($urandom), 1'b1, 1'b0, "endrop");
        check("endrop_novld", 32'(OUT_VALID), 32'd0);
        step(1'b1, 4'h0, 1'b1, 1'b0, "reen");
        step(1'b1, 4'($urandom), 1'b1, 1'b0, "reen");
        for (int i = 0; i < 3; i++) step(1'b1, 4'($urandom), 1'b1, 1'b0, "reen");
        check("reen_partial", 32'(OUT_VALID), 32'd0);
        step(1'b1, 4'($urandom), 1'b1, 1'b0, "reen");
        check("reen_vld", 32'(OUT_VALID), 32'd1);
        check("reen_seq", 32'(OUT_SEQ), 32'd4);

        // Asynchronous reset while a sample is held mid-window.
        step(1'b1, 4'($urandom), 1'b0, 1'b0, "prerst");
        check("prerst_vld", 32'(OUT_VALID), 32'd1);
        do_reset("rst_async");

        // Toggles 1,3,0,2 per cycle: total 6, peak 3.
        step(1'b1, 4'h0, 1'b1, 1'b0, "peak");
        step(1'b1, 4'h0, 1'b1, 1'b0, "peak");
        step(1'b1, 4'h1, 1'b1, 1'b0, "peak");
        step(1'b1, 4'h6, 1'b1, 1'b0, "peak");
        step(1'b1, 4'h6, 1'b1, 1'b0, "peak");
        step(1'b1, 4'h5, 1'b1, 1'b0, "peak");
        check("peak_sum", 32'(OUT_DATA), 32'd6);
`ifdef TOGGLE_MON_PEAK_EN
        check("peak_max", 32'(OUT_PEAK), 32'd3);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 15) != 0, 4'($urandom), 1'($urandom),
                 $urandom_range(0, 7) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
